// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM state encoding and the step-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter must hold the value N itself, hence N+1 distinct values.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor from R and keep the difference only when it did not go negative.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);

    logic [2*N:0] rq_shift;
    logic [N:0]   r_shift;
    logic [N-1:0] q_shift;
    logic [N:0]   trial;

    // Shift, trial-subtract and select the new remainder/quotient bit.
    always_comb begin
        // R never exceeds the divisor, so its top bit is always 0 before the shift.
        rq_shift = {r, q} << 1;
        r_shift  = rq_shift[2*N:N];
        q_shift  = rq_shift[N-1:0];
        trial    = r_shift - {1'b0, d};
        if (!trial[N]) begin
            r_next = trial;
            q_next = q_shift | {{(N-1){1'b0}}, 1'b1};
        end else begin
            r_next = r_shift;
            q_next = q_shift;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider, one quotient bit per clock.
// Holds the FSM, step counter, working registers and result registers.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);

    state_t         state_reg;
    state_t         state_next;
    logic [CW-1:0]  cnt_reg;
    logic [N-1:0]   q_reg;
    logic [N-1:0]   d_reg;
    logic [N:0]     r_reg;
    logic [N:0]     r_step;
    logic [N-1:0]   q_step;
    logic           accept;
    logic           last_step;

    div_step #(.N(N)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_step),
        .q_next (q_step)
    );

    // A new operation can be taken whenever the engine is not iterating.
    assign accept    = start && (state_reg != ST_RUN);
    assign last_step = (state_reg == ST_RUN) && (cnt_reg == CW'(1));

    // Next-state decode; a zero divisor skips straight to DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = (b == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register with busy/done registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy      <= (state_next == ST_RUN);
            done      <= (state_next == ST_DONE);
        end
    end

    // Working registers: load on accept, iterate while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= '0;
            d_reg   <= '0;
            r_reg   <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            q_reg   <= a;
            d_reg   <= b;
            r_reg   <= '0;
            cnt_reg <= CW'(N);
        end else if (state_reg == ST_RUN) begin
            q_reg   <= q_step;
            r_reg   <= r_step;
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    // Result registers change only when an operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && (b == '0)) begin
            quotient    <= '1;
            remainder   <= a;
            div_by_zero <= 1'b1;
        end else if (last_step) begin
            quotient    <= q_step;
            remainder   <= r_step[N-1:0];
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4): vector table, corner-case
// sequences, randomized operations and an exhaustive invariant sweep.
module tb_seq_divider;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int e0 = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } vec_t;

    vec_t tbl [6];

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    // Present operands with start for one edge, then scramble the inputs.
    task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = edge_cnt;
        a = N'($urandom);
        b = N'($urandom);
    endtask

    // Sample each cycle after the accept edge until done; lat is the number
    // of edges from the accept edge to the cycle where done is seen.
    task automatic wait_done(output int lat, output int bc);
        int guard;
        guard = 0;
        bc = 0;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            guard++;
        end
        lat = edge_cnt - e0;
        check("done_seen", done, 1);
    endtask

    task automatic do_div(input logic [N-1:0] av, input logic [N-1:0] bv, input bit inv_mode);
        int lat, bc, elat, ebc;
        logic [N-1:0] eq, er;
        logic edz;
        launch(av, bv);
        wait_done(lat, bc);
        if (bv == '0) begin
            eq = '1; er = av; edz = 1'b1; elat = 0; ebc = 0;
        end else begin
            eq = av / bv; er = av % bv; edz = 1'b0; elat = N; ebc = N;
        end
        $display("op a=%0d b=%0d -> q=%0d r=%0d dz=%0d lat=%0d busy_cycles=%0d",
                 av, bv, quotient, remainder, div_by_zero, lat, bc);
        if (inv_mode && bv != '0) begin
            check("inv_sum", int'(quotient) * int'(bv) + int'(remainder), av);
            check("inv_rem_lt_b", remainder < bv, 1);
            check("inv_dz", div_by_zero, 0);
        end else begin
            check("quotient", quotient, eq);
            check("remainder", remainder, er);
            check("div_by_zero", div_by_zero, edz);
        end
        check("latency", lat, elat);
        check("busy_cycles", bc, ebc);
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        int lat, bc, guard;
        bit seen;

        tbl[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0};
        tbl[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
        tbl[2] = '{a: 4'd3,  b: 4'd7,  q: 4'd0,  r: 4'd3, dz: 1'b0};
        tbl[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
        tbl[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
        tbl[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, dz: 1'b1};

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].a, tbl[i].b);
            wait_done(lat, bc);
            $display("vec %0d a=%0d b=%0d -> q=%0d r=%0d dz=%0d lat=%0d busy_cycles=%0d",
                     i, tbl[i].a, tbl[i].b, quotient, remainder, div_by_zero, lat, bc);
            check("vec_quotient", quotient, tbl[i].q);
            check("vec_remainder", remainder, tbl[i].r);
            check("vec_dz", div_by_zero, tbl[i].dz);
            check("vec_latency", lat, (tbl[i].b == '0) ? 0 : N);
            check("vec_busy_cycles", bc, (tbl[i].b == '0) ? 0 : N);
            @(negedge clk);
            check("vec_done_pulse", done, 0);
        end

        // Start and operand changes during a run are ignored
        launch(4'd13, 4'd3);
        @(negedge clk);
        start = 1'b1; a = 4'd2; b = 4'd1;
        @(negedge clk);
        start = 1'b0; a = 4'd9; b = 4'd6;
        wait_done(lat, bc);
        $display("ignored-start a=13 b=3 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        check("ign_quotient", quotient, 4);
        check("ign_remainder", remainder, 1);
        check("ign_latency", lat, N);
        @(negedge clk);

        // Back-to-back launch from the DONE cycle; previous result holds
        launch(4'd13, 4'd3);
        wait_done(lat, bc);
        check("b2b_first_q", quotient, 4);
        check("b2b_first_r", remainder, 1);
        start = 1'b1; a = 4'd14; b = 4'd4;
        @(negedge clk);
        start = 1'b0; e0 = edge_cnt; a = '0; b = '0;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            check("hold_q", quotient, 4);
            check("hold_r", remainder, 1);
            @(negedge clk);
            guard++;
        end
        check("b2b_done_seen", done, 1);
        lat = edge_cnt - e0;
        $display("back-to-back a=14 b=4 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        check("b2b_latency", lat, N);
        check("b2b_quotient", quotient, 3);
        check("b2b_remainder", remainder, 2);
        @(negedge clk);
        check("b2b_done_pulse", done, 0);

        // Reset in the middle of a run
        launch(4'd13, 4'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("mid-run reset -> busy=%0d done=%0d q=%0d r=%0d dz=%0d",
                 busy, done, quotient, remainder, div_by_zero);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_quotient", quotient, 0);
        check("mrst_remainder", remainder, 0);
        check("mrst_dz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check("mrst_no_done", seen, 0);

        // Randomized operations against plain arithmetic
        for (int i = 0; i < 40; i++) begin
            do_div(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), 1'b0);
        end

        // Exhaustive sweep against the division invariant
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                do_div(N'(ia), N'(ib), 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
